// File: rtl/hs_exerciser_pkg.sv
// Shared definitions for the handshake exerciser: source FSM encoding and
// error codes reported to the host.
package hs_exerciser_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_REQ_HI,
        S_REQ_LO,
        S_DONE,
        S_ERR
    } src_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_DATA    = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    // Same-cycle errors resolve as overrun > data > timeout.
    function automatic logic [1:0] err_pick(input logic ovr, input logic dat, input logic tmo);
        if (ovr)      return ERR_OVERRUN;
        else if (dat) return ERR_DATA;
        else if (tmo) return ERR_TIMEOUT;
        else          return ERR_NONE;
    endfunction

endpackage

// File: rtl/hs_sink_chan.sv
// One exit-channel consumer: synchronises req/dat, answers the 4-phase
// handshake, counts tokens and flags data mismatch or overrun.
module hs_sink_chan
    import hs_exerciser_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [CW-1:0] ntok,
    input  logic          req_i,
    input  logic          dat_i,
    output logic          ack_o,
    output logic [CW-1:0] rcv_cnt,
    output logic          err_data,
    output logic          err_ovr
);

    logic [SYNC_STAGES-1:0] req_sync, dat_sync;
    logic req_s, dat_s, req_q;
    logic req_rise, req_fall;

    assign req_s    = req_sync[SYNC_STAGES-1];
    assign dat_s    = dat_sync[SYNC_STAGES-1];
    assign req_rise = req_s && !req_q;
    assign req_fall = !req_s && req_q;

    // Error strobes are decoded from registered state so the top can
    // capture them on the same edge that raises ack.
    assign err_data = req_rise && (dat_s != rcv_cnt[0]);
    assign err_ovr  = req_rise && (rcv_cnt == ntok);

    always_ff @(posedge clk) begin
        if (rst) begin
            req_sync <= '0;
            dat_sync <= '0;
            req_q    <= 1'b0;
            ack_o    <= 1'b0;
            rcv_cnt  <= '0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], req_i};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], dat_i};
            req_q    <= req_s;
            if (req_rise && rcv_cnt != ntok) begin
                ack_o <= 1'b1;
            end else if (req_fall && ack_o) begin
                ack_o   <= 1'b0;
                rcv_cnt <= rcv_cnt + CW'(1);
            end
            if (clr) rcv_cnt <= '0;
        end
    end

endmodule

// File: rtl/hs_exerciser.sv
// Clocked exerciser for the self-timed pipeline: sources a counted 0,1,0,1
// token stream on the entry channel and consumes NSINK exit channels.
module hs_exerciser
    import hs_exerciser_pkg::*;
#(
    parameter int NSINK       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int CW          = 16,
    parameter int TIMEOUT     = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CW-1:0]       ntok,
    output logic                req_o,
    input  logic                ack_i,
    output logic                dat_o,
    input  logic [NSINK-1:0]    req_i,
    output logic [NSINK-1:0]    ack_o,
    input  logic [NSINK-1:0]    dat_i,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [CW-1:0]       sent_cnt,
    output logic [NSINK*CW-1:0] rcv_cnt,
    output logic [CW-1:0]       max_lat
);

    localparam int TW = $clog2(TIMEOUT + 1);

    src_state_t               state;
    logic [CW-1:0]            ntok_q, lat, sent_nxt;
    logic [TW-1:0]            wait_cnt;
    logic [SYNC_STAGES-1:0]   ack_sync;
    logic                     ack_s, run_start, tmo, all_rcvd, any_ovr, any_data;
    logic [NSINK-1:0]         snk_err_data, snk_err_ovr;
    logic [NSINK-1:0][CW-1:0] rcv_arr;

    assign ack_s     = ack_sync[SYNC_STAGES-1];
    assign run_start = start && (state == S_IDLE);
    assign any_ovr   = |snk_err_ovr;
    assign any_data  = |snk_err_data;
    assign sent_nxt  = sent_cnt + CW'(1);
    assign rcv_cnt   = rcv_arr;
    // Timeout only fires while still waiting for the ack edge of this phase.
    assign tmo = (((state == S_REQ_HI) && !ack_s) || ((state == S_REQ_LO) && ack_s))
                 && (wait_cnt == TW'(TIMEOUT));

    always_comb begin
        all_rcvd = 1'b1;
        for (int k = 0; k < NSINK; k++)
            if (rcv_arr[k] != ntok_q) all_rcvd = 1'b0;
    end

    for (genvar g = 0; g < NSINK; g++) begin : g_sink
        hs_sink_chan #(.SYNC_STAGES(SYNC_STAGES), .CW(CW)) u_sink (
            .clk      (clk),
            .rst      (rst),
            .clr      (run_start),
            .ntok     (ntok_q),
            .req_i    (req_i[g]),
            .dat_i    (dat_i[g]),
            .ack_o    (ack_o[g]),
            .rcv_cnt  (rcv_arr[g]),
            .err_data (snk_err_data[g]),
            .err_ovr  (snk_err_ovr[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ack_sync <= '0;
            ntok_q   <= '0;
            lat      <= '0;
            wait_cnt <= '0;
            req_o    <= 1'b0;
            dat_o    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            sent_cnt <= '0;
            max_lat  <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_i};

            // Sticky first-error capture; sinks can flag errors in any state.
            if (run_start) begin
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end else if (!err && (any_ovr || any_data || tmo)) begin
                err      <= 1'b1;
                err_code <= err_pick(any_ovr, any_data, tmo);
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        ntok_q   <= ntok;
                        sent_cnt <= '0;
                        max_lat  <= '0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        dat_o    <= 1'b0;
                        state    <= (ntok == '0) ? S_DONE : S_SETUP;
                    end
                end
                S_SETUP: begin
                    req_o    <= 1'b1;
                    lat      <= CW'(1);
                    wait_cnt <= TW'(1);
                    state    <= S_REQ_HI;
                end
                S_REQ_HI: begin
                    if (ack_s) begin
                        if (lat > max_lat) max_lat <= lat;
                        req_o    <= 1'b0;
                        wait_cnt <= TW'(1);
                        state    <= S_REQ_LO;
                    end else if (tmo) begin
                        busy  <= 1'b0;
                        state <= S_ERR;
                    end else begin
                        if (lat != '1) lat <= lat + CW'(1);
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                S_REQ_LO: begin
                    if (!ack_s) begin
                        sent_cnt <= sent_nxt;
                        dat_o    <= sent_nxt[0];
                        state    <= (sent_nxt < ntok_q) ? S_SETUP : S_DONE;
                    end else if (tmo) begin
                        busy  <= 1'b0;
                        state <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                S_DONE: begin
                    if (err || any_ovr || any_data) begin
                        busy  <= 1'b0;
                        state <= S_ERR;
                    end else if (all_rcvd) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_hs_exerciser.sv
// Bench for hs_exerciser: a behavioural loopback pipeline feeds every entry
// token to both sinks; a token-level model bounds the DUT counters each cycle.
`timescale 1ns/1ps
module tb_hs_exerciser;
    import hs_exerciser_pkg::*;

    localparam int NSINK = 2, SYNC = 2, CW = 16, TMO = 1023, SNK_DLY = 5;

    logic clk = 1'b0;
    logic rst, start;
    logic [CW-1:0] ntok;
    logic req_o, ack_i, dat_o;
    logic [NSINK-1:0] req_i, ack_o, dat_i;
    logic busy, done, err;
    logic [1:0] err_code;
    logic [CW-1:0] sent_cnt, max_lat;
    logic [NSINK*CW-1:0] rcv_cnt;

    always #5 clk = ~clk;

    hs_exerciser #(.NSINK(NSINK), .SYNC_STAGES(SYNC), .CW(CW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .ntok(ntok),
        .req_o(req_o), .ack_i(ack_i), .dat_o(dat_o),
        .req_i(req_i), .ack_o(ack_o), .dat_i(dat_i),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .sent_cnt(sent_cnt), .rcv_cnt(rcv_cnt), .max_lat(max_lat)
    );

    int checks = 0, failures = 0;

    // Token-level model of the current run.
    int  ent_dly = 5;
    bit  resp_en = 1'b1;
    bit  chk_en  = 1'b0;
    int  mdl_ntok, mdl_rise, mdl_fall, mdl_max_lat;
    int  mdl_rfall [NSINK];
    int  snk_idx   [NSINK];
    bit  ovr_exp   [NSINK];
    bit  snk_q     [NSINK][$];
    logic [15:0] dat_seq;
    int  inv_k = -1, inv_tok = -1;
    logic [1:0] code_at_err;
    int  rcv1_at_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic int rcv(input int k);
        return int'(rcv_cnt[k*CW +: CW]);
    endfunction

    // Entry side of the loopback: ack after ent_dly cycles per edge, fan token out.
    initial begin : entry_resp
        ack_i = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en && !rst && req_o && !ack_i) begin
                chk("dat_o_parity", dat_o, mdl_rise % 2);
                dat_seq[mdl_rise % 16] = dat_o;
                mdl_rise++;
                for (int k = 0; k < NSINK; k++) snk_q[k].push_back(dat_o);
                repeat (ent_dly) @(negedge clk);
                ack_i = 1'b1;
                if (ent_dly + SYNC + 1 > mdl_max_lat) mdl_max_lat = ent_dly + SYNC + 1;
            end else if (ack_i && !req_o) begin
                repeat (ent_dly) @(negedge clk);
                ack_i = 1'b0;
                mdl_fall++;
            end
        end
    end

    // Exit side: each sink replays queued tokens as 4-phase handshakes.
    for (genvar g = 0; g < NSINK; g++) begin : g_snk
        logic r = 1'b0, d = 1'b0;
        assign req_i[g] = r;
        assign dat_i[g] = d;
        initial begin
            forever begin
                @(negedge clk);
                if (snk_q[g].size() != 0) begin
                    bit b;
                    int n;
                    b = snk_q[g].pop_front();
                    if (g == inv_k && snk_idx[g] == inv_tok) b = ~b;
                    snk_idx[g]++;
                    d = b;
                    repeat (SNK_DLY) @(negedge clk);
                    r = 1'b1;
                    n = 0;
                    while (!ack_o[g] && n < 40) begin @(negedge clk); n++; end
                    if (!ack_o[g]) begin
                        if (!ovr_exp[g]) chk($sformatf("snk%0d_ack_rise", g), ack_o[g], 1);
                        r = 1'b0;
                    end else begin
                        repeat (SNK_DLY) @(negedge clk);
                        r = 1'b0;
                        mdl_rfall[g]++;
                        n = 0;
                        while (ack_o[g] && n < 40) begin @(negedge clk); n++; end
                        chk($sformatf("snk%0d_ack_fall", g), ack_o[g], 0);
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the token-level model.
    initial begin : compare
        bit prev_err;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("busy_done_excl", busy & done, 0);
                chk("err_code_vs_err", err_code != 2'b00, err);
                if (req_o) chk("dat_o_token", dat_o, sent_cnt[0]);
                chk_rng("sent_cnt", int'(sent_cnt), (mdl_fall > 0) ? mdl_fall - 1 : 0, mdl_fall);
                for (int k = 0; k < NSINK; k++)
                    chk_rng($sformatf("rcv_cnt%0d", k), rcv(k),
                            (mdl_rfall[k] > 0) ? mdl_rfall[k] - 1 : 0, mdl_rfall[k]);
                chk_rng("max_lat", int'(max_lat), 0, mdl_max_lat);
                if (err && !prev_err) begin
                    code_at_err = err_code;
                    rcv1_at_err = rcv(1);
                end
            end
            prev_err = err;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_req_o"}, req_o, 0);
        chk({tag, "_dat_o"}, dat_o, 0);
        chk({tag, "_ack_o"}, ack_o, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_err_code"}, err_code, 0);
        chk({tag, "_sent_cnt"}, sent_cnt, 0);
        chk({tag, "_rcv_cnt"}, rcv_cnt, 0);
        chk({tag, "_max_lat"}, max_lat, 0);
    endtask

    task automatic start_run(input int n);
        @(negedge clk);
        chk_en = 1'b0;
        mdl_ntok = n; mdl_rise = 0; mdl_fall = 0; mdl_max_lat = 0; dat_seq = '0;
        for (int k = 0; k < NSINK; k++) begin mdl_rfall[k] = 0; snk_idx[k] = 0; end
        ntok  = CW'(n);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin @(negedge clk); n++; end
        chk("run_finished", busy, 0);
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!req_o && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_req_rise"}, req_o, 1);
    endtask

    task automatic do_reset(input string tag);
        chk_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero(tag);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int c;
        rst = 1'b1; start = 1'b0; ntok = '0;
        for (int k = 0; k < NSINK; k++) begin ovr_exp[k] = 1'b0; mdl_rfall[k] = 0; snk_idx[k] = 0; end
        mdl_fall = 0; mdl_rise = 0; mdl_max_lat = 0; mdl_ntok = 0;
        repeat (3) @(negedge clk);
        check_zero("por");
        rst = 1'b0;

        // Loopback, 4 tokens, 5-cycle response: latency 5 + 2 sync + 1 = 8.
        start_run(4);
        wait_idle(600);
        chk("lb_done", done, 1);
        chk("lb_err", err, 0);
        chk("lb_sent", sent_cnt, 4);
        chk("lb_rcv0", rcv(0), 4);
        chk("lb_rcv1", rcv(1), 4);
        chk("lb_max_lat", max_lat, 8);
        chk("lb_max_lat_mdl", max_lat, mdl_max_lat);
        chk("lb_mdl_lat", mdl_max_lat, 8);
        chk("lb_dat_seq", dat_seq[3:0], 4'b1010);
        chk("lb_tokens", mdl_rise, 4);

        // Zero-length run.
        start_run(0);
        chk("z_busy", busy, 1);
        chk("z_done_early", done, 0);
        @(negedge clk);
        chk("z_done", done, 1);
        chk("z_busy_clr", busy, 0);
        chk("z_req", req_o, 0);
        chk("z_sent", sent_cnt, 0);

        // Sink 1 sees inverted data on token 1.
        inv_k = 1; inv_tok = 1; code_at_err = 2'b00; rcv1_at_err = -1;
        start_run(4);
        wait_idle(600);
        repeat (20) @(negedge clk);
        chk("mm_code_at_err", code_at_err, ERR_DATA);
        chk("mm_rcv1_at_err", rcv1_at_err, 1);
        chk("mm_err", err, 1);
        chk("mm_err_code", err_code, ERR_DATA);
        chk("mm_done", done, 0);
        chk("mm_rcv0", rcv(0), 4);
        chk("mm_rcv1", rcv(1), 4);
        inv_k = -1; inv_tok = -1;
        do_reset("mm_rst");

        // Entry ack never arrives: error exactly TIMEOUT cycles after req_o rises.
        resp_en = 1'b0;
        start_run(1);
        wait_req("tmo");
        c = 0;
        while (!err && c < 1100) begin @(negedge clk); c++; end
        chk("tmo_cycles", c, 1023);
        chk("tmo_err_code", err_code, ERR_TIMEOUT);
        chk("tmo_busy", busy, 0);
        chk("tmo_req_held", req_o, 1);
        chk("tmo_done", done, 0);
        repeat (5) @(negedge clk);
        chk("tmo_req_frozen", req_o, 1);
        do_reset("tmo_rst");

        // Reset while in REQ_HI, then a clean 3-token run with 7-cycle response.
        start_run(3);
        wait_req("rq");
        repeat (3) @(negedge clk);
        do_reset("rq_rst");
        resp_en = 1'b1;
        ent_dly = 7;
        start_run(3);
        wait_idle(600);
        chk("rr_done", done, 1);
        chk("rr_err", err, 0);
        chk("rr_sent", sent_cnt, 3);
        chk("rr_rcv0", rcv(0), 3);
        chk("rr_rcv1", rcv(1), 3);
        chk("rr_max_lat", max_lat, 10);

        // Extra token on sink 0 after a completed 2-token run.
        ent_dly = 5;
        start_run(2);
        wait_idle(600);
        chk("ov_done", done, 1);
        chk("ov_rcv0_pre", rcv(0), 2);
        ovr_exp[0] = 1'b1;
        snk_q[0].push_back(1'b0);
        repeat (80) @(negedge clk);
        chk("ov_err", err, 1);
        chk("ov_err_code", err_code, ERR_OVERRUN);
        chk("ov_rcv0", rcv(0), 2);
        chk("ov_ack0", ack_o[0], 0);
        chk("ov_busy", busy, 0);
        ovr_exp[0] = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
